// File: rtl/hazard_control_unit.sv
// Hazard/stall controller for the 5-stage core: load-use and branch stalls,
// taken-branch squash, dmem freeze, timeout flag and stall-cycle counter.
module hazard_control_unit #(
  parameter int         REG_ADDR_WIDTH = 5,
  parameter logic [6:0] BRANCH_OPCODE  = 7'b1100111,
  parameter int         MEM_TIMEOUT    = 64,
  parameter int         CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [6:0]                IF_ID_inst_opcode,
  input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
  input  logic                      ID_EX_mem_rd_en,
  input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd,
  input  logic                      EX_MEM_mem_rd_en,
  input  logic [REG_ADDR_WIDTH-1:0] EX_MEM_rd,
  input  logic                      EX_MEM_mem_req,
  input  logic                      dmem_ready,
  input  logic                      branch_taken,
  output logic                      pc_wr_en,
  output logic                      IF_ID_wr_en,
  output logic                      ID_EX_wr_en,
  output logic                      EX_MEM_wr_en,
  output logic                      IF_ID_flush,
  output logic                      ID_EX_flush,
  output logic                      MEM_WB_flush,
  output logic                      mem_wait,
  output logic                      mem_timeout,
  output logic [CNT_WIDTH-1:0]      stall_cycles
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t               state_q, state_d;
  logic [WW-1:0]        wait_cnt_q, wait_cnt_d;
  logic                 mem_timeout_q, mem_timeout_d;
  logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;

  logic uses_rs1, uses_rs2, br;
  logic freeze, haz_a, haz_b, stall;

  always_comb begin
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    unique case (IF_ID_inst_opcode)
      7'b0110111, 7'b0010111, 7'b1101111: uses_rs1 = 1'b0;
      default: ;
    endcase
    if (IF_ID_inst_opcode == 7'b0110011 ||
        IF_ID_inst_opcode == 7'b0100011 ||
        IF_ID_inst_opcode == BRANCH_OPCODE)
      uses_rs2 = 1'b1;
    br = (IF_ID_inst_opcode == BRANCH_OPCODE);

    freeze = EX_MEM_mem_req & ~dmem_ready;
    haz_a  = ID_EX_mem_rd_en & (ID_EX_rd != '0) &
             ((uses_rs1 & (ID_EX_rd == IF_ID_rs1)) |
              (uses_rs2 & (ID_EX_rd == IF_ID_rs2)));
    haz_b  = br & EX_MEM_mem_rd_en & (EX_MEM_rd != '0) &
             ((EX_MEM_rd == IF_ID_rs1) | (EX_MEM_rd == IF_ID_rs2));
    stall  = ~freeze & (haz_a | haz_b);
  end

  // Enables/flushes pass through untouched while reset is held.
  always_comb begin
    pc_wr_en     = 1'b1;
    IF_ID_wr_en  = 1'b1;
    ID_EX_wr_en  = 1'b1;
    EX_MEM_wr_en = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    MEM_WB_flush = 1'b0;
    if (rst_n) begin
      if (freeze) begin
        pc_wr_en     = 1'b0;
        IF_ID_wr_en  = 1'b0;
        ID_EX_wr_en  = 1'b0;
        EX_MEM_wr_en = 1'b0;
        MEM_WB_flush = 1'b1;
      end else if (stall) begin
        pc_wr_en    = 1'b0;
        IF_ID_wr_en = 1'b0;
        ID_EX_flush = 1'b1;
      end else if (br && branch_taken) begin
        IF_ID_flush = 1'b1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    mem_timeout_d  = mem_timeout_q;
    stall_cycles_d = stall_cycles_q;
    unique case (state_q)
      RUN:      if (freeze)  state_d = MEM_WAIT;
      MEM_WAIT: if (!freeze) state_d = RUN;
      default:  state_d = RUN;
    endcase
    if (!freeze)
      wait_cnt_d = '0;
    else if (wait_cnt_q != WW'(MEM_TIMEOUT))
      wait_cnt_d = wait_cnt_q + 1'b1;
    if (freeze && wait_cnt_q == WW'(MEM_TIMEOUT - 1))
      mem_timeout_d = 1'b1;
    if (!pc_wr_en && stall_cycles_q != '1)
      stall_cycles_d = stall_cycles_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= RUN;
      wait_cnt_q     <= '0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign mem_wait     = (state_q == MEM_WAIT);
  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit (MEM_TIMEOUT=4, CNT_WIDTH=4).
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opc = 7'b0110011;
  logic [4:0] rs1 = '0, rs2 = '0, ex_rd = '0, mm_rd = '0;
  logic       ex_ld = 0, mm_ld = 0, req = 0, rdy = 0, bt = 0;
  logic       pc_en, ifid_en, idex_en, exmem_en;
  logic       ifid_fl, idex_fl, memwb_fl;
  logic       mw, to;
  logic [3:0] sc;

  always #5 clk = ~clk;

  hazard_control_unit #(
    .REG_ADDR_WIDTH(5), .BRANCH_OPCODE(7'b1100111),
    .MEM_TIMEOUT(4), .CNT_WIDTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_inst_opcode(opc), .IF_ID_rs1(rs1), .IF_ID_rs2(rs2),
    .ID_EX_mem_rd_en(ex_ld), .ID_EX_rd(ex_rd),
    .EX_MEM_mem_rd_en(mm_ld), .EX_MEM_rd(mm_rd),
    .EX_MEM_mem_req(req), .dmem_ready(rdy), .branch_taken(bt),
    .pc_wr_en(pc_en), .IF_ID_wr_en(ifid_en),
    .ID_EX_wr_en(idex_en), .EX_MEM_wr_en(exmem_en),
    .IF_ID_flush(ifid_fl), .ID_EX_flush(idex_fl),
    .MEM_WB_flush(memwb_fl),
    .mem_wait(mw), .mem_timeout(to), .stall_cycles(sc)
  );

  typedef struct packed {
    logic [3:0] en;
    logic [2:0] fl;
    logic       mw;
    logic       to;
    logic [3:0] sc;
  } exp_t;

  localparam logic [3:0] E1 = 4'b1111, ES = 4'b0011, EF = 4'b0000;
  localparam logic [2:0] F0 = 3'b000, FS = 3'b010;
  localparam logic [2:0] FF = 3'b001, FB = 3'b100;
  localparam logic [6:0] ADD = 7'b0110011, BR = 7'b1100111;
  localparam logic [6:0] LUI = 7'b0110111, ADDI = 7'b0010011;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   vec = 0;

  task automatic chk(input string nm, input int v,
                     input logic [3:0] act, input logic [3:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%b required=%b", nm, v, act, req_v);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("enables", vec, {pc_en, ifid_en, idex_en, exmem_en}, e.en);
      chk("flushes", vec, {1'b0, ifid_fl, idex_fl, memwb_fl}, {1'b0, e.fl});
      chk("mem_wait", vec, {3'b0, mw}, {3'b0, e.mw});
      chk("mem_timeout", vec, {3'b0, to}, {3'b0, e.to});
      chk("stall_cycles", vec, sc, e.sc);
      vec++;
    end
  end

  task automatic drive(
    input logic rn, input logic [6:0] o,
    input logic [4:0] r1, input logic [4:0] r2,
    input logic el, input logic [4:0] erd,
    input logic ml, input logic [4:0] mrd,
    input logic rq, input logic rd, input logic b,
    input logic [3:0] en, input logic [2:0] fl,
    input logic emw, input logic eto, input logic [3:0] esc);
    exp_t e;
    rst_n = rn; opc = o; rs1 = r1; rs2 = r2;
    ex_ld = el; ex_rd = erd; mm_ld = ml; mm_rd = mrd;
    req = rq; rdy = rd; bt = b;
    e.en = en; e.fl = fl; e.mw = emw; e.to = eto; e.sc = esc;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic emw, input logic eto,
                      input logic [3:0] esc);
    drive(1, ADD, 1, 2, 0, 0, 0, 0, 0, 0, 0, E1, F0, emw, eto, esc);
  endtask

  task automatic frz(input logic rn, input logic [3:0] en,
                     input logic [2:0] fl, input logic emw,
                     input logic eto, input logic [3:0] esc);
    drive(rn, ADD, 5, 1, 1, 5, 0, 0, 1, 0, 0, en, fl, emw, eto, esc);
  endtask

  initial begin
    @(posedge clk);
    #1;
    drive(0, ADD, 1, 2, 0, 0, 0, 0, 0, 0, 0, E1, F0, 0, 0, 0);
    idle(0, 0, 0);
    // load x5 in EX, ADD x6,x5,x1 in ID
    drive(1, ADD, 5, 1, 1, 5, 0, 0, 0, 0, 0, ES, FS, 0, 0, 0);
    drive(1, ADD, 5, 1, 0, 0, 1, 5, 1, 1, 0, E1, F0, 0, 0, 1);
    idle(0, 0, 1);
    // branch behind load x7: hazA then hazB, taken ignored
    drive(1, BR, 3, 7, 1, 7, 0, 0, 0, 0, 1, ES, FS, 0, 0, 1);
    drive(1, BR, 3, 7, 0, 0, 1, 7, 1, 1, 1, ES, FS, 0, 0, 2);
    drive(1, BR, 3, 7, 0, 0, 0, 0, 0, 0, 1, E1, FB, 0, 0, 3);
    drive(1, BR, 3, 7, 0, 0, 0, 0, 0, 0, 0, E1, F0, 0, 0, 3);
    // rd=0 and unused source registers never stall
    drive(1, ADD, 0, 0, 1, 0, 1, 0, 0, 0, 0, E1, F0, 0, 0, 3);
    drive(1, LUI, 5, 0, 1, 5, 0, 0, 0, 0, 0, E1, F0, 0, 0, 3);
    drive(1, ADDI, 1, 5, 1, 5, 0, 0, 0, 0, 0, E1, F0, 0, 0, 3);
    drive(1, BR, 1, 2, 0, 0, 1, 0, 0, 0, 1, E1, FB, 0, 0, 3);
    // 3-cycle freeze with a pending hazard, then the stall appears
    frz(1, EF, FF, 0, 0, 3);
    frz(1, EF, FF, 1, 0, 4);
    frz(1, EF, FF, 1, 0, 5);
    drive(1, ADD, 5, 1, 1, 5, 0, 0, 1, 1, 0, ES, FS, 1, 0, 6);
    idle(0, 0, 7);
    // 6-cycle freeze: timeout after the 4th cycle, sticky
    drive(1, ADD, 1, 2, 0, 0, 0, 0, 1, 0, 0, EF, FF, 0, 0, 7);
    drive(1, ADD, 1, 2, 0, 0, 0, 0, 1, 0, 0, EF, FF, 1, 0, 8);
    drive(1, ADD, 1, 2, 0, 0, 0, 0, 1, 0, 0, EF, FF, 1, 0, 9);
    drive(1, ADD, 1, 2, 0, 0, 0, 0, 1, 0, 0, EF, FF, 1, 0, 10);
    drive(1, ADD, 1, 2, 0, 0, 0, 0, 1, 0, 0, EF, FF, 1, 1, 11);
    drive(1, ADD, 1, 2, 0, 0, 0, 0, 1, 0, 0, EF, FF, 1, 1, 12);
    idle(1, 1, 13);
    idle(0, 1, 13);
    idle(0, 1, 13);
    // reset during freeze plus load-use hazard
    frz(1, EF, FF, 0, 1, 13);
    frz(0, E1, F0, 1, 1, 14);
    frz(1, EF, FF, 0, 0, 0);
    idle(1, 0, 1);
    idle(0, 0, 1);
    // long freeze: counter saturates at all-ones
    for (int i = 0; i < 18; i++)
      drive(1, ADD, 1, 2, 0, 0, 0, 0, 1, 0, 0, EF, FF,
            logic'(i >= 1), logic'(i >= 4),
            (i + 1 > 15) ? 4'd15 : 4'(i + 1));
    idle(1, 1, 15);
    idle(0, 1, 15);
    for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
